// File: rtl/inst_buffer.sv
// Instruction buffer between the icache stage and the decoder.
// A circular FIFO of single-instruction entries. It accepts fetch packets of
// up to two instructions and hands the oldest one or two instructions to the
// decoder. There is no bypass path: an instruction reaches the decoder outputs
// one cycle after it is pushed. Flush and reset empty the buffer.
module inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int PRED_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  icache_valid_i,
  output logic                  icache_ready_o,
  input  logic [63:0]           icache_insts_i,
  input  logic [31:0]           icache_pc_i,
  input  logic [1:0]            icache_mask_i,
  input  logic [2*PRED_W-1:0]   icache_pred_i,
  output logic [1:0]            dec_valid_o,
  output logic [63:0]           dec_insts_o,
  output logic [63:0]           dec_pc_o,
  output logic [2*PRED_W-1:0]   dec_pred_o,
  input  logic                  dec_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Accepting a packet needs room for two entries, whatever its mask.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  // Number of set bits in a two-bit slot mask.
  function automatic logic [CW-1:0] slot_count(input logic [1:0] bits);
    return CW'(bits[0]) + CW'(bits[1]);
  endfunction

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];
  logic [PRED_W-1:0] pred_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [PW-1:0] head_nx1;
  logic [PW-1:0] tail_nx1;
  logic          push;
  logic          pop;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  assign head_nx1 = head + PW'(1);
  assign tail_nx1 = tail + PW'(1);

  // Ready depends only on the registered occupancy and flush.
  always_comb icache_ready_o = (count <= READY_MAX) && !flush_i;

  // Decoder slot valids: oldest first, never a lone upper slot.
  always_comb begin
    dec_valid_o = 2'b00;
    if (!flush_i) begin
      if (count >= CW'(2))      dec_valid_o = 2'b11;
      else if (count == CW'(1)) dec_valid_o = 2'b01;
    end
  end

  assign push   = icache_valid_i && icache_ready_o;
  assign pop    = dec_ready_i && (|dec_valid_o);
  assign push_n = push ? slot_count(icache_mask_i) : '0;
  assign pop_n  = pop  ? slot_count(dec_valid_o)   : '0;

  // Pointer and occupancy update; flush wins over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + push_n - pop_n;
    end
  end

  // Entry storage; a lone upper slot is packed into the tail entry.
  always_ff @(posedge clk) begin
    if (push) begin
      case (icache_mask_i)
        2'b11: begin
          inst_mem[tail]     <= icache_insts_i[31:0];
          pc_mem[tail]       <= icache_pc_i;
          pred_mem[tail]     <= icache_pred_i[PRED_W-1:0];
          inst_mem[tail_nx1] <= icache_insts_i[63:32];
          pc_mem[tail_nx1]   <= icache_pc_i + 32'd4;
          pred_mem[tail_nx1] <= icache_pred_i[2*PRED_W-1:PRED_W];
        end
        2'b01: begin
          inst_mem[tail] <= icache_insts_i[31:0];
          pc_mem[tail]   <= icache_pc_i;
          pred_mem[tail] <= icache_pred_i[PRED_W-1:0];
        end
        2'b10: begin
          inst_mem[tail] <= icache_insts_i[63:32];
          pc_mem[tail]   <= icache_pc_i + 32'd4;
          pred_mem[tail] <= icache_pred_i[2*PRED_W-1:PRED_W];
        end
        default: ;
      endcase
    end
  end

  // Decoder data: head and head+1, zeroed in slots that are not valid.
  always_comb begin
    dec_insts_o = '0;
    dec_pc_o    = '0;
    dec_pred_o  = '0;
    if (dec_valid_o[0]) begin
      dec_insts_o[31:0]       = inst_mem[head];
      dec_pc_o[31:0]          = pc_mem[head];
      dec_pred_o[PRED_W-1:0]  = pred_mem[head];
    end
    if (dec_valid_o[1]) begin
      dec_insts_o[63:32]             = inst_mem[head_nx1];
      dec_pc_o[63:32]                = pc_mem[head_nx1];
      dec_pred_o[2*PRED_W-1:PRED_W]  = pred_mem[head_nx1];
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed scenarios followed by random traffic, all
// checked against a queue-based model of the buffer contents.
module tb_inst_buffer;

  localparam int DEPTH  = 8;
  localparam int PRED_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush_i = 1'b0;
  logic                icache_valid_i = 1'b0;
  logic                icache_ready_o;
  logic [63:0]         icache_insts_i = '0;
  logic [31:0]         icache_pc_i = '0;
  logic [1:0]          icache_mask_i = '0;
  logic [2*PRED_W-1:0] icache_pred_i = '0;
  logic [1:0]          dec_valid_o;
  logic [63:0]         dec_insts_o;
  logic [63:0]         dec_pc_o;
  logic [2*PRED_W-1:0] dec_pred_o;
  logic                dec_ready_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  ent_t q[$];

  inst_buffer #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .icache_valid_i (icache_valid_i),
    .icache_ready_o (icache_ready_o),
    .icache_insts_i (icache_insts_i),
    .icache_pc_i    (icache_pc_i),
    .icache_mask_i  (icache_mask_i),
    .icache_pred_i  (icache_pred_i),
    .dec_valid_o    (dec_valid_o),
    .dec_insts_o    (dec_insts_o),
    .dec_pc_o       (dec_pc_o),
    .dec_pred_o     (dec_pred_o),
    .dec_ready_i    (dec_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model at the current time.
  task automatic check_outputs(input string tag);
    logic        exp_rdy;
    logic [1:0]  exp_v;
    logic [63:0] ei, ep, ed;
    exp_rdy = (q.size() <= DEPTH - 2) && !flush_i;
    exp_v   = 2'b00;
    if (!flush_i && q.size() >= 2)      exp_v = 2'b11;
    else if (!flush_i && q.size() == 1) exp_v = 2'b01;
    ei = '0; ep = '0; ed = '0;
    if (exp_v[0]) begin
      ei[31:0] = q[0].inst; ep[31:0] = q[0].pc; ed[31:0] = q[0].pred;
    end
    if (exp_v[1]) begin
      ei[63:32] = q[1].inst; ep[63:32] = q[1].pc; ed[63:32] = q[1].pred;
    end
    chk({tag, ".ready"}, 64'(icache_ready_o), 64'(exp_rdy));
    chk({tag, ".valid"}, 64'(dec_valid_o), 64'(exp_v));
    chk({tag, ".insts"}, dec_insts_o, ei);
    chk({tag, ".pc"}, dec_pc_o, ep);
    chk({tag, ".pred"}, dec_pred_o, ed);
  endtask

  // One clock cycle: drive at the falling edge, check, then apply the model at the rising edge.
  task automatic cycle(input string tag, input logic v, input logic [1:0] m,
                       input logic [63:0] insts, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic [63:0] pred;
    int          npop;
    logic        acc;
    ent_t        e;
    pred = {$urandom(), $urandom()};
    @(negedge clk);
    icache_valid_i = v;
    icache_mask_i  = m;
    icache_insts_i = insts;
    icache_pc_i    = pc;
    icache_pred_i  = pred;
    dec_ready_i    = rdy;
    flush_i        = fl;
    #1;
    check_outputs(tag);
    acc  = v && !fl && (q.size() <= DEPTH - 2);
    npop = (rdy && !fl) ? ((q.size() >= 2) ? 2 : q.size()) : 0;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      repeat (npop) void'(q.pop_front());
      if (acc && m[0]) begin
        e.inst = insts[31:0]; e.pc = pc; e.pred = pred[31:0];
        q.push_back(e);
      end
      if (acc && m[1]) begin
        e.inst = insts[63:32]; e.pc = pc + 32'd4; e.pred = pred[63:32];
        q.push_back(e);
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rpc();
    return $urandom() & 32'hFFFF_FFF8;
  endfunction

  function automatic logic [63:0] rins();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle();
    icache_valid_i = 1'b0;
    dec_ready_i    = 1'b0;
    flush_i        = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held.
    #1;
    check_outputs("reset");
    chk("reset.ready1", 64'(icache_ready_o), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Two-instruction packet into an empty buffer, decoder stalled.
    cycle("p2", 1'b1, 2'b11, 64'h00000002_00000001, 32'h1c000000, 1'b0, 1'b0);
    chk("p2.valid_const", 64'(dec_valid_o), 64'h3);
    chk("p2.pc_const", dec_pc_o, 64'h1c000004_1c000000);
    chk("p2.insts_const", dec_insts_o, 64'h00000002_00000001);
    cycle("p2_flush", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b1);

    // Upper slot only.
    cycle("hi", 1'b1, 2'b10, 64'hAAAA5555_12345678, 32'h1c000008, 1'b0, 1'b0);
    chk("hi.valid_const", 64'(dec_valid_o), 64'h1);
    chk("hi.pc_const", 64'(dec_pc_o[31:0]), 64'h1c00000c);
    chk("hi.inst_const", 64'(dec_insts_o[31:0]), 64'hAAAA5555);
    chk("hi.upper_zero", dec_insts_o[63:32], 64'h0);
    cycle("hi_pop", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);
    cycle("hi_empty", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b0);

    // Fill to seven entries: not ready.
    for (int i = 0; i < 3; i++) cycle("fill7", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("fill7", 1'b1, 2'b01, rins(), rpc(), 1'b0, 1'b0);
    chk("cnt7.ready", 64'(icache_ready_o), 64'd0);
    cycle("cnt7_push", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("cnt7_flush", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b1);

    // Fill to eight entries; fifth packet refused.
    for (int i = 0; i < 4; i++) cycle("fill8", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    chk("cnt8.ready", 64'(icache_ready_o), 64'd0);
    cycle("cnt8_push5", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain8", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);
    cycle("drain8_empty", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b0);

    // Count 3 with head at entry 4, then push+pop across the wrap.
    cycle("wrap_flush", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("wrap_fill", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("wrap_pop", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);
    cycle("wrap_pop", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);
    cycle("wrap_one", 1'b1, 2'b01, rins(), rpc(), 1'b0, 1'b0);
    cycle("wrap_both", 1'b1, 2'b11, rins(), rpc(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);

    // Flush with five entries and a packet being offered.
    for (int i = 0; i < 2; i++) cycle("fl_fill", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("fl_fill", 1'b1, 2'b01, rins(), rpc(), 1'b0, 1'b0);
    cycle("fl_during", 1'b1, 2'b11, rins(), rpc(), 1'b1, 1'b1);
    cycle("fl_after", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("fl_next", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with six entries, then push on the first edge after release.
    cycle("ar_flush", 1'b0, 2'b00, 64'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("ar_fill", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    q.delete();
    check_outputs("async_rst");
    chk("async_rst.ready1", 64'(icache_ready_o), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    cycle("post_rst", 1'b1, 2'b11, rins(), rpc(), 1'b0, 1'b0);
    cycle("post_rst_seen", 1'b0, 2'b00, 64'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rins(), rpc(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
